// File: rtl/muldiv_iter_unit_if.sv
// Mul/div handshake bundle between the EX-stage requester and the iterative mul/div unit.
interface muldiv_iter_unit_if #(parameter int WIDTH = 32);
  logic             Exception_clean;
  logic             StallE;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall;
  logic             done;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output Exception_clean, StallE, start, op, a, b,
    input  stall, done, busy, hi, lo
  );

  modport slave (
    input  Exception_clean, StallE, start, op, a, b,
    output stall, done, busy, hi, lo
  );
endinterface

// File: rtl/muldiv_iter_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit: 32 steps on magnitudes, sign fix-up when the result is registered.
module muldiv_iter_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic rst,
  muldiv_iter_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  stateT            state, stateNext;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       opReg;
  logic             signA, signB;
  logic [WIDTH-1:0] rawA, opA, opB;
  logic [WIDTH-1:0] accHi, accLo;
  logic [WIDTH-1:0] hiReg, loReg;
  logic             accept, stallInt, lastStep;
  logic [WIDTH-1:0] absA, absB;
  logic [WIDTH:0]   mulSum, divTrial;
  logic [WIDTH-1:0] stepHi, stepLo, finalHi, finalLo;
  logic [2*WIDTH-1:0] prodNeg;

  // Signed ops run on magnitudes; signs are remembered for the final correction.
  assign absA = (~bus.op[0] & bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign absB = (~bus.op[0] & bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign lastStep = (state == BUSY) && (cnt == CNT_W'(WIDTH - 1));

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    stateNext = state;
    stallInt  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        accept   = bus.start & ~bus.Exception_clean;
        stallInt = accept;
        if (accept) stateNext = BUSY;
      end
      BUSY: begin
        stallInt = 1'b1;
        if (lastStep) stateNext = DONE;
      end
      DONE: begin
        if (!bus.StallE) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (bus.Exception_clean) stateNext = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // One step: multiply shifts {accHi,accLo} right after a conditional add; divide is restoring shift-subtract.
  always_comb begin
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opA} : '0);
    divTrial = {accHi, accLo[WIDTH-1]} - {1'b0, opB};
    if (opReg[1]) begin
      if (!divTrial[WIDTH]) begin
        stepHi = divTrial[WIDTH-1:0];
        stepLo = {accLo[WIDTH-2:0], 1'b1};
      end else begin
        stepHi = {accHi[WIDTH-2:0], accLo[WIDTH-1]};
        stepLo = {accLo[WIDTH-2:0], 1'b0};
      end
    end else begin
      stepHi = mulSum[WIDTH:1];
      stepLo = {mulSum[0], accLo[WIDTH-1:1]};
    end
  end

  always_comb begin
    prodNeg = -{stepHi, stepLo};
    finalHi = stepHi;
    finalLo = stepLo;
    if (!opReg[1]) begin
      if (signA ^ signB) {finalHi, finalLo} = prodNeg;
    end else if (opB == '0) begin
      finalHi = rawA;
      finalLo = '1;
    end else begin
      if (signA ^ signB) finalLo = -stepLo;
      if (signA)         finalHi = -stepHi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      hiReg <= '0;
      loReg <= '0;
    end else if (bus.Exception_clean || accept) begin
      cnt <= '0;
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
      if (lastStep) begin
        hiReg <= finalHi;
        loReg <= finalLo;
      end
    end
  end

  // NOTE: operand/accumulator registers have no reset; they are always loaded on acceptance before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      opReg <= bus.op;
      signA <= ~bus.op[0] & bus.a[WIDTH-1];
      signB <= ~bus.op[0] & bus.b[WIDTH-1];
      rawA  <= bus.a;
      opA   <= absA;
      opB   <= absB;
      accHi <= '0;
      accLo <= bus.op[1] ? absA : absB;
    end else if (state == BUSY) begin
      accHi <= stepHi;
      accLo <= stepLo;
    end
  end

  assign bus.stall = stallInt;
  assign bus.done  = (state == DONE);
  assign bus.busy  = (state != IDLE);
  assign bus.hi    = hiReg;
  assign bus.lo    = loReg;
endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Randomised and directed bench for muldiv_iter_unit against a plain-arithmetic reference model.
module tb_muldiv_iter_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] lastHi = '0;
  logic [31:0] lastLo = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vecT;

  muldiv_iter_unit_if #(.WIDTH(32)) bus ();
  muldiv_iter_unit #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: 64-bit integer arithmetic, with the architectural divide-by-zero result.
  function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00:   r = 64'(sa * sb);
      2'b01:   r = {32'b0, a} * {32'b0, b};
      2'b10:   r = (b == 0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
      default: r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
    endcase
    return r;
  endfunction

  // Drives one instruction starting at the next negedge with StallE following stall.
  task automatic runOp(input logic [1:0] opv, input logic [31:0] av, input logic [31:0] bv,
                       output int stallCnt, output int doneCyc,
                       output logic [31:0] hiO, output logic [31:0] loO);
    @(negedge clk);
    bus.start = 1'b1; bus.op = opv; bus.a = av; bus.b = bv; bus.Exception_clean = 1'b0;
    stallCnt = 0; doneCyc = -1; hiO = '0; loO = '0;
    for (int c = 0; c < 40; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      bus.StallE = bus.stall;
      if (bus.stall) stallCnt++;
      if (bus.done) begin
        doneCyc = c; hiO = bus.hi; loO = bus.lo;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'hFFFF; bus.b = 32'h3;
    bus.StallE = 1'b0; bus.Exception_clean = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
    bus.start = 1'b0; #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    vecT vecs[$];
    int sc, dc;
    logic [31:0] h, l;
    vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1});
    vecs.push_back('{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
    vecs.push_back('{2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF});
    vecs.push_back('{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF});
    vecs.push_back('{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
    vecs.push_back('{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
    foreach (vecs[i]) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, sc, dc, h, l);
      checks++; if (sc !== 33) begin errors++; $display("FAIL dir%0d_stall_cycles: got %0d expected 33", i, sc); end
      checks++; if (dc !== 33) begin errors++; $display("FAIL dir%0d_done_cycle: got %0d expected 33", i, dc); end
      checks++; if (h !== vecs[i].hi) begin errors++; $display("FAIL dir%0d_hi: got %h expected %h", i, h, vecs[i].hi); end
      checks++; if (l !== vecs[i].lo) begin errors++; $display("FAIL dir%0d_lo: got %h expected %h", i, l, vecs[i].lo); end
      lastHi = vecs[i].hi; lastLo = vecs[i].lo;
    end
  endtask

  task automatic test_random();
    int sc, dc;
    logic [31:0] h, l, av, bv;
    logic [1:0] opv;
    logic [63:0] exp;
    for (int i = 0; i < 24; i++) begin
      opv = 2'($urandom_range(0, 3));
      av  = $urandom;
      case ($urandom_range(0, 7))
        0:       bv = 32'h0;
        1, 2:    bv = $urandom_range(1, 16);
        3:       bv = -$urandom_range(1, 16);
        default: bv = $urandom;
      endcase
      exp = refModel(opv, av, bv);
      runOp(opv, av, bv, sc, dc, h, l);
      checks++; if (dc !== 33) begin errors++; $display("FAIL rnd%0d_done_cycle: got %0d expected 33", i, dc); end
      checks++; if ({h, l} !== exp) begin
        errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h_%h expected %h_%h", i, opv, av, bv, h, l, exp[63:32], exp[31:0]);
      end
      lastHi = exp[63:32]; lastLo = exp[31:0];
    end
  endtask

  task automatic test_flush();
    logic sawDone = 1'b0;
    int sc, dc;
    logic [31:0] h, l;
    logic [63:0] exp;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'hDEADBEEF; bus.b = 32'h00000013; bus.Exception_clean = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      if (c != 0) @(negedge clk);
      if (c == 10) bus.Exception_clean = 1'b1;
      #1;
      bus.StallE = bus.stall;
      if (bus.done) sawDone = 1'b1;
    end
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL flush_c10_stall: got %b expected 1", bus.stall); end
    @(negedge clk);
    bus.Exception_clean = 1'b0; bus.start = 1'b0; bus.StallE = 1'b0; #1;
    checks++; if (sawDone !== 1'b0) begin errors++; $display("FAIL flush_early_done: got %b expected 0", sawDone); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL flush_done: got %b expected 0", bus.done); end
    checks++; if (bus.hi !== lastHi) begin errors++; $display("FAIL flush_hi_kept: got %h expected %h", bus.hi, lastHi); end
    checks++; if (bus.lo !== lastLo) begin errors++; $display("FAIL flush_lo_kept: got %h expected %h", bus.lo, lastLo); end
    // Cycle 12 start must complete at cycle 12 + 33 = 45.
    exp = refModel(2'b11, 32'hCAFEF00D, 32'h00000007);
    runOp(2'b11, 32'hCAFEF00D, 32'h00000007, sc, dc, h, l);
    checks++; if (dc !== 33) begin errors++; $display("FAIL flush_restart_done_cycle: got %0d expected 33", dc); end
    checks++; if ({h, l} !== exp) begin errors++; $display("FAIL flush_restart_result: got %h_%h expected %h", h, l, exp); end
    lastHi = exp[63:32]; lastLo = exp[31:0];
    // A flush in IDLE blocks acceptance.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.Exception_clean = 1'b1; bus.StallE = 1'b0; #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall: got %b expected 0", bus.stall); end
    @(negedge clk);
    bus.start = 1'b0; bus.Exception_clean = 1'b0; #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_hold();
    logic [63:0] exp, exp2;
    int sc, dc, doneAt;
    logic [31:0] h, l;
    exp = refModel(2'b00, 32'h00012345, 32'hFFFF0001);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'h00012345; bus.b = 32'hFFFF0001; bus.Exception_clean = 1'b0;
    doneAt = -1;
    for (int c = 0; c < 40; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (bus.done) begin bus.StallE = 1'b1; doneAt = c; break; end
      bus.StallE = bus.stall;
    end
    checks++; if (doneAt !== 33) begin errors++; $display("FAIL hold_done_cycle: got %0d expected 33", doneAt); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL hold%0d_done: got %b expected 1", k, bus.done); end
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL hold%0d_stall: got %b expected 0", k, bus.stall); end
      checks++; if ({bus.hi, bus.lo} !== exp) begin errors++; $display("FAIL hold%0d_result: got %h_%h expected %h", k, bus.hi, bus.lo, exp); end
    end
    bus.StallE = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL hold_release_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL hold_release_done: got %b expected 0", bus.done); end
    exp2 = refModel(2'b10, 32'h87654321, 32'h00000100);
    runOp(2'b10, 32'h87654321, 32'h00000100, sc, dc, h, l);
    checks++; if (sc !== 33) begin errors++; $display("FAIL hold_next_stall_cycles: got %0d expected 33", sc); end
    checks++; if ({h, l} !== exp2) begin errors++; $display("FAIL hold_next_result: got %h_%h expected %h", h, l, exp2); end
    lastHi = exp2[63:32]; lastLo = exp2[31:0];
  endtask

  task automatic test_flush_done();
    int doneAt = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'h0000FFFF; bus.b = 32'h0000FFFF; bus.Exception_clean = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (bus.done) begin bus.StallE = 1'b1; doneAt = c; break; end
      bus.StallE = bus.stall;
    end
    checks++; if (doneAt !== 33) begin errors++; $display("FAIL flushdone_done_cycle: got %0d expected 33", doneAt); end
    @(negedge clk);
    bus.Exception_clean = 1'b1; #1;
    @(negedge clk);
    bus.Exception_clean = 1'b0; bus.start = 1'b0; bus.StallE = 1'b0; #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL flushdone_done: got %b expected 0", bus.done); end
    checks++; if ({bus.hi, bus.lo} !== 64'h00000000FFFE0001) begin
      errors++; $display("FAIL flushdone_result: got %h_%h expected 00000000_fffe0001", bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'h11111111; bus.b = 32'h22222222; bus.StallE = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1; bus.Exception_clean = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; bus.StallE = 1'b0; #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
    checks++; if ({bus.hi, bus.lo} !== 64'h0) begin errors++; $display("FAIL midreset_result: got %h_%h expected 0", bus.hi, bus.lo); end
    rst = 1'b0;
    lastHi = '0; lastLo = '0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_hold();
    test_flush_done();
    test_reset_midop();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
- Iterative 32-bit multiply/divide unit in the EX stage; executes MULT, MULTU, DIV and DIVU.
- It is the requester side of the hazard unit's mul/div handshake. It drives stall while an operation runs and pulses/holds done when the result is ready.
- Results go to the HI/LO write path, which captures hi/lo while done=1.

Parameters:
- WIDTH, 32, operand width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- Exception_clean  input  1  pipeline flush from exception logic; aborts any operation.
- StallE  input  1  EX stage stall from hazard unit; 0 means the EX instruction advances at this edge.
- start  input  1  EX instruction is a valid mul/div this cycle.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- a  input  WIDTH  rs operand (multiplicand/dividend).
- b  input  WIDTH  rt operand (multiplier/divisor).
- stall  output  1  operation accepted or in progress, result not yet ready.
- done  output  1  hi/lo valid for the EX instruction.
- busy  output  1  state is not IDLE.
- hi  output  WIDTH  product[63:32] or remainder.
- lo  output  WIDTH  product[31:0] or quotient.

Behaviour:
- Reset (rst=1 at an edge): state IDLE, hi=lo=0, counter=0, done=0. Reset wins over every other input.
- States:
  - IDLE: stall = start & ~Exception_clean (combinational); done=0. If start=1 and Exception_clean=0: latch op, |a| and |b| (signed ops), the sign bits, and zero the accumulator; counter=0; go to BUSY.
  - BUSY: stall=1, done=0. One radix-2 step per cycle; counter increments. Multiply is shift-add over 64 bits. Divide is restoring shift-subtract giving a 32-bit quotient and remainder. After the 32nd step (counter==31), go to DONE.
  - DONE: stall=0, done=1. hi/lo are registered on entry, with sign correction applied. If StallE=0 go to IDLE; else stay in DONE with done held at 1 and hi/lo stable. start is ignored in DONE, so the same instruction never restarts.
- Latency: start seen in cycle 0, BUSY in cycles 1..32, DONE in cycle 33. stall=1 for cycles 0..32 (33 cycles).
- A new start is accepted in the first IDLE cycle after leaving DONE. Back-to-back ops therefore incur no dead cycle beyond the instruction advancing.
- Signed multiply: 64-bit product is negated if sign_a ^ sign_b.
- Signed divide:
  - Quotient truncates toward zero; negated if sign_a ^ sign_b.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (signed or unsigned): lo=0xFFFFFFFF, hi=a (raw operand). Latency is the same as a normal divide.
- Exception_clean=1 in any state: next state IDLE, done=0 next cycle, hi/lo keep their previous values, counter cleared. In IDLE it also blocks acceptance that cycle.
- Exception_clean has priority over start and StallE. rst has priority over Exception_clean.
- busy = (state != IDLE). Outputs are glitch-free registered values except stall in IDLE.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, StallE follows stall -> stall=1 cycles 0..32; done=1 at cycle 33; hi=0xFFFFFFFE lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1 at cycle 33.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x12345678 b=0 -> lo=0xFFFFFFFF, hi=0x12345678, done at cycle 33.
- Exception_clean pulsed at cycle 10 of a DIVU -> IDLE at cycle 11; done never asserts; hi/lo unchanged. A new start at cycle 12 completes normally at cycle 45.
- After done, hold StallE=1 with start=1 for 5 cycles -> done stays 1, stall=0, hi/lo stable, no restart. Drop StallE -> IDLE next cycle. A new start is then accepted with stall=1.
